serial_adder: RTL

- Multi-cycle, parametrised N-bit adder/subtractor for the ALU datapath.
- Replaces a single-cycle gate-level adder chain with a registered digit-serial engine that processes DIGIT bits per clock.
- Uses a valid/ready handshake on both input and output.
- Produces sum, carry and the status flags (zero, negative, overflow) used by the ALU flag logic.

---
 rtl/serial_adder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder: digit-serial N-bit add/sub engine that handles DIGIT bits per clock.
// It uses valid/ready handshakes on both sides and produces sum, carry and the zero/negative/overflow flags.
module serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);
    localparam int NSTEPS = WIDTH / DIGIT;
    localparam int SW = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(NSTEPS - 1);

    generate
        if (WIDTH % DIGIT != 0) begin : g_badWidth
            $fatal(1, "serial_adder: WIDTH must be an integer multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_opA;
    logic [WIDTH-1:0] r_opB;
    logic             r_carryIn;
    logic [SW-1:0]    r_step;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_overflow;
    logic             r_zero;
    logic             r_negative;

    int               w_base;
    logic [DIGIT-1:0] w_sliceA;
    logic [DIGIT-1:0] w_sliceB;
    logic [DIGIT:0]   w_digitSum;
    logic [WIDTH-1:0] w_fullSum;

    // One digit of the addition, merged into the partial sum so the last step sees the complete result.
    always_comb begin
        w_base     = int'(r_step) * DIGIT;
        w_sliceA   = r_opA[w_base +: DIGIT];
        w_sliceB   = r_opB[w_base +: DIGIT];
        w_digitSum = {1'b0, w_sliceA} + {1'b0, w_sliceB} + {{DIGIT{1'b0}}, r_carryIn};
        w_fullSum  = r_sum;
        w_fullSum[w_base +: DIGIT] = w_digitSum[DIGIT-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (r_step == LAST_STEP) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Subtraction is folded into addition at accept time: B is inverted and the carry-in seeded with 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opA      <= '0;
            r_opB      <= '0;
            r_carryIn  <= 1'b0;
            r_step     <= '0;
            r_sum      <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
            r_negative <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_opA  <= a;
                        r_step <= '0;
                        case (op)
                            2'b00: begin
                                r_opB     <= b;
                                r_carryIn <= 1'b0;
                            end
                            2'b01: begin
                                r_opB     <= ~b;
                                r_carryIn <= 1'b1;
                            end
                            2'b10: begin
                                r_opB     <= '0;
                                r_carryIn <= 1'b1;
                            end
                            default: begin
                                r_opB     <= b;
                                r_carryIn <= cin;
                            end
                        endcase
                    end
                end
                RUN: begin
                    r_sum     <= w_fullSum;
                    r_carryIn <= w_digitSum[DIGIT];
                    r_step    <= r_step + 1'b1;
                    if (r_step == LAST_STEP) begin
                        r_carry    <= w_digitSum[DIGIT];
                        r_overflow <= (r_opA[WIDTH-1] == r_opB[WIDTH-1]) &&
                                      (w_fullSum[WIDTH-1] != r_opA[WIDTH-1]);
                        r_zero     <= (w_fullSum == '0);
                        r_negative <= w_fullSum[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum      = r_sum;
    assign carry    = r_carry;
    assign overflow = r_overflow;
    assign zero     = r_zero;
    assign negative = r_negative;

endmodule
